hough_vote_accum: RTL and testbench
===================================

HOUGH_VOTE_ACCUM -- requirements
Module: hough_vote_accum

Interface
REQ-001 SHALL have parameter THETAS, default 180: number of theta bins.
REQ-002 SHALL have parameter RHOS, default 512: number of rho bins per theta.
REQ-003 SHALL have parameter LANES, default 4: parallel vote lanes; THETAS SHALL be a multiple of LANES.
REQ-004 SHALL have parameter ACCUM_BITS, default 16: accumulator bin width.
REQ-005 SHALL have parameter CLEAR_ON_READ, default 1: bin zeroed as it is read out.
REQ-006 SHALL have port clock, input, 1: rising-edge clock.
REQ-007 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port vote_valid, input, LANES: per-lane vote present.
REQ-009 SHALL have port vote_theta, input, LANES*clog2(THETAS): per-lane theta index.
REQ-010 SHALL have port vote_rho, input, LANES*clog2(RHOS): per-lane rho index.
REQ-011 SHALL have port vote_ready, output, 1: all lanes accepted this cycle when high.
REQ-012 SHALL have port frame_end, input, 1: single-cycle pulse, no more votes this frame.
REQ-013 SHALL have port out_empty, output, 1: low when data_out is valid.
REQ-014 SHALL have port out_rd_en, input, 1: pop data_out.
REQ-015 SHALL have port data_out, output, ACCUM_BITS: bin count.
REQ-016 SHALL have port out_last, output, 1: high with final bin of the frame.
REQ-017 SHALL have port lane_err, output, 1: sticky, vote dropped for bad lane/index.

Function
REQ-018 SHALL store bins in LANES banks; bank l holds thetas with theta mod LANES == l, THETAS/LANES*RHOS words each.
REQ-019 SHALL implement states INIT, VOTE, DRAIN, READ.
REQ-020 INIT SHALL write zero to every bank address, one per cycle, THETAS/LANES*RHOS cycles, vote_ready=0, then go to VOTE.
REQ-021 In VOTE, vote_ready SHALL be 1; a lane vote is accepted when vote_valid[l] and vote_ready are high on a clock edge.
REQ-022 Each accepted vote SHALL do read-modify-write: read at cycle N, bin+1 written at N+1.
REQ-023 Back-to-back votes to the same bin SHALL forward the pending write value; no increment lost.
REQ-024 Increment SHALL saturate at 2^ACCUM_BITS-1.
REQ-025 A vote on lane l with theta mod LANES != l, theta >= THETAS or rho >= RHOS SHALL be dropped and SHALL set lane_err until reset.
REQ-026 frame_end in VOTE SHALL move to DRAIN; votes valid in the same cycle SHALL still be counted.
REQ-027 DRAIN SHALL hold vote_ready=0 until the RMW pipeline is empty (≤2 cycles), then go to READ.
REQ-028 READ SHALL present bins theta-major: theta 0..THETAS-1, rho 0..RHOS-1 within each theta.
REQ-029 First bin SHALL be valid (out_empty=0) no later than 3 cycles after entering READ.
REQ-030 data_out SHALL be held stable while out_empty=0 and out_rd_en=0.
REQ-031 out_rd_en while out_empty=1 SHALL be ignored.
REQ-032 With out_rd_en held high, one bin SHALL be delivered per cycle after first-bin latency.
REQ-033 With CLEAR_ON_READ=1, each bin SHALL be zeroed when popped; with 0, contents SHALL be kept.
REQ-034 After popping the out_last bin, SHALL return to VOTE (CLEAR_ON_READ=1) or INIT (CLEAR_ON_READ=0).
REQ-035 frame_end outside VOTE SHALL be ignored.

Reset
REQ-036 While reset=0, SHALL force state INIT, address counters 0, vote_ready=0, out_empty=1, data_out=0, out_last=0, lane_err=0.
REQ-037 Reset asserted mid-VOTE or mid-READ SHALL abort the operation; bins SHALL be re-zeroed by INIT after release.

Verification
(THETAS=8, RHOS=16, LANES=2, ACCUM_BITS=4, CLEAR_ON_READ=1)
REQ-038 Release reset -> vote_ready rises after 64 INIT cycles; frame_end then full readout -> 128 zeros, out_last only on word 127.
REQ-039 Lane0 (theta 2, rho 5) on 3 consecutive cycles, lane1 (theta 3, rho 5) once, frame_end -> word 37=3, word 53=1, all others 0.
REQ-040 20 votes to (theta 0, rho 0) -> word 0 = 15 (saturated).
REQ-041 Lane1 vote theta 2 -> lane_err=1, all bins 0; second frame with no votes -> all zeros, lane_err still 1.
REQ-042 Readout with out_rd_en toggled 1010... -> data_out stable while unpopped, 128 words in order, immediate second readout all zeros.
REQ-043 reset pulsed at word 40 of readout -> out_empty=1 at once, INIT reruns, next frame reads all zeros.

Source files
------------

// File: rtl/hough_vote_accum_if.sv
// Vote-in / bin-out bundle for hough_vote_accum.
// The master drives votes, frame_end and out_rd_en; the slave returns ready, bins and status.
interface hough_vote_accum_if #(
  parameter int THETAS     = 180,
  parameter int RHOS       = 512,
  parameter int LANES      = 4,
  parameter int ACCUM_BITS = 16
);
  localparam int TW = $clog2(THETAS);
  localparam int RW = $clog2(RHOS);

  logic [LANES-1:0]    vote_valid;
  logic [LANES*TW-1:0] vote_theta;
  logic [LANES*RW-1:0] vote_rho;
  logic                vote_ready;
  logic                frame_end;
  logic                out_empty;
  logic                out_rd_en;
  logic [ACCUM_BITS-1:0] data_out;
  logic                out_last;
  logic                lane_err;

  modport master (
    output vote_valid, vote_theta, vote_rho, frame_end, out_rd_en,
    input  vote_ready, out_empty, data_out, out_last, lane_err
  );

  modport slave (
    input  vote_valid, vote_theta, vote_rho, frame_end, out_rd_en,
    output vote_ready, out_empty, data_out, out_last, lane_err
  );
endinterface

// File: rtl/hough_vote_accum.sv
// Banked Hough vote accumulator: 2-cycle read-modify-write per vote, theta-major readout.
// Votes stall (vote_ready=0) outside VOTE; readout is show-ahead with out_rd_en pops.
module hough_vote_accum #(
  parameter int THETAS        = 180,
  parameter int RHOS          = 512,
  parameter int LANES         = 4,
  parameter int ACCUM_BITS    = 16,
  parameter int CLEAR_ON_READ = 1
) (
  input logic               clock,
  input logic               reset,
  hough_vote_accum_if.slave bus
);
  localparam int TW    = $clog2(THETAS);
  localparam int RW    = $clog2(RHOS);
  localparam int DEPTH = THETAS / LANES * RHOS;
  localparam int AW    = $clog2(DEPTH);
  localparam int BW    = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [1:0] S_INIT  = 2'd0;
  localparam logic [1:0] S_VOTE  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_READ  = 2'd3;

  localparam logic [ACCUM_BITS-1:0] SAT_MAX = '1;

  logic [1:0]            state;
  logic [ACCUM_BITS-1:0] mem [LANES][DEPTH];
  logic [AW-1:0]         init_addr;

  logic [LANES-1:0]      accept;
  logic [LANES-1:0]      v_ok;
  logic [AW-1:0]         v_addr [LANES];
  logic [LANES-1:0]      p_vld;
  logic [AW-1:0]         p_addr [LANES];
  logic [ACCUM_BITS-1:0] p_dat  [LANES];
  logic [ACCUM_BITS-1:0] p_inc  [LANES];
  logic                  lane_err;

  logic [BW-1:0]         rd_bank;
  logic [AW-1:0]         rd_base;
  logic [RW-1:0]         rd_rho;
  logic [AW-1:0]         rd_addr;
  logic                  rd_last;
  logic                  rd_done;
  logic                  out_empty_q;
  logic [ACCUM_BITS-1:0] data_q;
  logic                  last_q;
  logic [BW-1:0]         out_bank;
  logic [AW-1:0]         out_addr;
  logic                  pop;
  logic                  load;

  assign accept = bus.vote_valid & {LANES{state == S_VOTE}};

  // Lane l owns thetas with theta mod LANES == l; anything else is a routing error.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [TW-1:0] th;
    logic [RW-1:0] rh;
    assign th        = bus.vote_theta[g*TW +: TW];
    assign rh        = bus.vote_rho[g*RW +: RW];
    assign v_ok[g]   = (32'(th) % LANES == g) && (32'(th) < THETAS) && (32'(rh) < RHOS);
    assign v_addr[g] = AW'((32'(th) / LANES) * RHOS + 32'(rh));
    assign p_inc[g]  = (p_dat[g] == SAT_MAX) ? p_dat[g] : p_dat[g] + ACCUM_BITS'(1);
  end

  // Read stage of the RMW; a hit on the bin being written this cycle takes the new value.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      p_vld    <= '0;
      lane_err <= 1'b0;
      for (int l = 0; l < LANES; l++) begin
        p_addr[l] <= '0;
        p_dat[l]  <= '0;
      end
    end else begin
      for (int l = 0; l < LANES; l++) begin
        p_vld[l] <= accept[l] && v_ok[l];
        if (accept[l] && v_ok[l]) begin
          p_addr[l] <= v_addr[l];
          p_dat[l]  <= (p_vld[l] && p_addr[l] == v_addr[l]) ? p_inc[l] : mem[l][v_addr[l]];
        end
        if (accept[l] && !v_ok[l])
          lane_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int l = 0; l < LANES; l++) begin
      if (state == S_INIT)
        mem[l][init_addr] <= '0;
      else if (p_vld[l])
        mem[l][p_addr[l]] <= p_inc[l];
      else if (CLEAR_ON_READ != 0 && pop && 32'(out_bank) == l)
        mem[l][out_addr] <= '0;
    end
  end

  assign rd_addr = rd_base + AW'(rd_rho);
  assign rd_last = (32'(rd_bank) == LANES - 1) && (32'(rd_base) == DEPTH - RHOS)
                && (32'(rd_rho) == RHOS - 1);
  assign pop     = bus.out_rd_en && !out_empty_q;
  assign load    = (state == S_READ) && !rd_done && (out_empty_q || pop);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_INIT;
      init_addr   <= '0;
      rd_bank     <= '0;
      rd_base     <= '0;
      rd_rho      <= '0;
      rd_done     <= 1'b0;
      out_empty_q <= 1'b1;
      data_q      <= '0;
      last_q      <= 1'b0;
      out_bank    <= '0;
      out_addr    <= '0;
    end else begin
      case (state)
        S_INIT: begin
          init_addr <= init_addr + AW'(1);
          if (32'(init_addr) == DEPTH - 1) begin
            init_addr <= '0;
            state     <= S_VOTE;
          end
        end
        S_VOTE: if (bus.frame_end) state <= S_DRAIN;
        S_DRAIN: if (p_vld == '0) state <= S_READ;
        default: begin
          if (load) begin
            data_q      <= mem[rd_bank][rd_addr];
            out_bank    <= rd_bank;
            out_addr    <= rd_addr;
            last_q      <= rd_last;
            out_empty_q <= 1'b0;
            if (rd_last) begin
              rd_done <= 1'b1;
            end else if (32'(rd_rho) == RHOS - 1) begin
              rd_rho <= '0;
              if (32'(rd_bank) == LANES - 1) begin
                rd_bank <= '0;
                rd_base <= rd_base + AW'(RHOS);
              end else begin
                rd_bank <= rd_bank + BW'(1);
              end
            end else begin
              rd_rho <= rd_rho + RW'(1);
            end
          end else if (pop) begin
            out_empty_q <= 1'b1;
            last_q      <= 1'b0;
          end
          if (pop && last_q) begin
            state   <= (CLEAR_ON_READ != 0) ? S_VOTE : S_INIT;
            rd_done <= 1'b0;
            rd_bank <= '0;
            rd_base <= '0;
            rd_rho  <= '0;
          end
        end
      endcase
    end
  end

  assign bus.vote_ready = (state == S_VOTE);
  assign bus.out_empty  = out_empty_q;
  assign bus.data_out   = data_q;
  assign bus.out_last   = last_q;
  assign bus.lane_err   = lane_err;
endmodule

// File: tb/tb_hough_vote_accum.sv
// Directed bench for hough_vote_accum with 8 thetas x 16 rhos, 2 lanes, 4-bit bins.
module tb_hough_vote_accum;
  localparam int THETAS = 8;
  localparam int RHOS   = 16;
  localparam int LANES  = 2;
  localparam int AB     = 4;
  localparam int NW     = THETAS * RHOS;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  hough_vote_accum_if #(.THETAS(THETAS), .RHOS(RHOS), .LANES(LANES), .ACCUM_BITS(AB)) bus ();

  hough_vote_accum #(
    .THETAS(THETAS), .RHOS(RHOS), .LANES(LANES), .ACCUM_BITS(AB), .CLEAR_ON_READ(1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int          vectors     = 0;
  int          miscompares = 0;
  logic [AB-1:0] rd_words [NW];
  logic          rd_last  [NW];
  logic [AB-1:0] exp_w    [NW];
  int          rd_count;
  int          rd_unstable;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic vote(input logic v0, input int t0, input int r0,
                      input logic v1, input int t1, input int r1, input logic fe);
    bus.vote_valid = {v1, v0};
    bus.vote_theta = {3'(t1), 3'(t0)};
    bus.vote_rho   = {4'(r1), 4'(r0)};
    bus.frame_end  = fe;
    step();
    bus.vote_valid = '0;
    bus.frame_end  = 1'b0;
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (bus.vote_ready !== 1'b1 && cyc < 500) begin
      step();
      cyc++;
    end
  endtask

  // Pops up to limit words; with toggle, out_rd_en alternates 1,0,1,0...
  task automatic collect(input bit toggle, input int limit);
    int cyc = 0;
    bit held = 1'b0;
    bit pop;
    logic [AB-1:0] held_dat = '0;
    rd_count    = 0;
    rd_unstable = 0;
    for (int i = 0; i < NW; i++) begin
      rd_words[i] = 'x;
      rd_last[i]  = 1'bx;
    end
    while (rd_count < limit && cyc < 3000) begin
      pop = toggle ? (cyc % 2 == 0) : 1'b1;
      if (bus.out_empty === 1'b0) begin
        if (held && bus.data_out !== held_dat) rd_unstable++;
        if (pop) begin
          rd_words[rd_count] = bus.data_out;
          rd_last[rd_count]  = bus.out_last;
          rd_count++;
          held = 1'b0;
        end else begin
          held     = 1'b1;
          held_dat = bus.data_out;
        end
      end else begin
        held = 1'b0;
      end
      bus.out_rd_en = pop;
      step();
      cyc++;
    end
    bus.out_rd_en = 1'b0;
  endtask

  task automatic clear_exp();
    for (int i = 0; i < NW; i++) exp_w[i] = '0;
  endtask

  task automatic test_reset();
    int cyc;
    reset = 1'b0;
    bus.vote_valid = '0; bus.vote_theta = '0; bus.vote_rho = '0;
    bus.frame_end = 1'b0; bus.out_rd_en = 1'b0;
    repeat (3) step();
    vectors++; if (bus.vote_ready !== 1'b0) begin miscompares++; $display("FAIL reset_vote_ready got %b want 0", bus.vote_ready); end
    vectors++; if (bus.out_empty !== 1'b1) begin miscompares++; $display("FAIL reset_out_empty got %b want 1", bus.out_empty); end
    vectors++; if (bus.data_out !== 4'd0) begin miscompares++; $display("FAIL reset_data_out got %0d want 0", bus.data_out); end
    vectors++; if (bus.out_last !== 1'b0) begin miscompares++; $display("FAIL reset_out_last got %b want 0", bus.out_last); end
    vectors++; if (bus.lane_err !== 1'b0) begin miscompares++; $display("FAIL reset_lane_err got %b want 0", bus.lane_err); end
    reset = 1'b1;
    wait_ready(cyc);
    vectors++; if (cyc !== 64) begin miscompares++; $display("FAIL init_cycles got %0d want 64", cyc); end
  endtask

  task automatic test_empty_frame();
    int nlast = 0;
    clear_exp();
    vote(0, 0, 0, 0, 0, 0, 1);
    collect(1'b0, NW);
    vectors++; if (rd_count !== NW) begin miscompares++; $display("FAIL empty_count got %0d want %0d", rd_count, NW); end
    for (int w = 0; w < NW; w++) begin
      vectors++;
      if (rd_words[w] !== exp_w[w]) begin miscompares++; $display("FAIL empty_word %0d got %0d want %0d", w, rd_words[w], exp_w[w]); end
      if (rd_last[w] === 1'b1) nlast++;
    end
    vectors++; if (nlast !== 1 || rd_last[NW-1] !== 1'b1) begin miscompares++; $display("FAIL empty_last got %0d flags (word127=%b) want 1 on word 127", nlast, rd_last[NW-1]); end
    vectors++; if (bus.vote_ready !== 1'b1) begin miscompares++; $display("FAIL empty_back_to_vote got %b want 1", bus.vote_ready); end
  endtask

  task automatic test_votes();
    clear_exp();
    exp_w[37] = 4'd3;
    exp_w[53] = 4'd1;
    vote(1, 2, 5, 1, 3, 5, 0);
    vote(1, 2, 5, 0, 0, 0, 0);
    vote(1, 2, 5, 0, 0, 0, 1);
    vectors++; if (bus.vote_ready !== 1'b0) begin miscompares++; $display("FAIL drain_ready got %b want 0", bus.vote_ready); end
    collect(1'b0, NW);
    vectors++; if (rd_count !== NW) begin miscompares++; $display("FAIL votes_count got %0d want %0d", rd_count, NW); end
    for (int w = 0; w < NW; w++) begin
      vectors++;
      if (rd_words[w] !== exp_w[w]) begin miscompares++; $display("FAIL votes_word %0d got %0d want %0d", w, rd_words[w], exp_w[w]); end
    end
    vectors++; if (bus.lane_err !== 1'b0) begin miscompares++; $display("FAIL votes_lane_err got %b want 0", bus.lane_err); end
  endtask

  task automatic test_saturate();
    clear_exp();
    exp_w[0]  = 4'd15;
    exp_w[31] = 4'd7;
    for (int i = 0; i < 20; i++) vote(1, 0, 0, (i < 7), 1, 15, 0);
    vote(0, 0, 0, 0, 0, 0, 1);
    collect(1'b0, NW);
    vectors++; if (rd_count !== NW) begin miscompares++; $display("FAIL sat_count got %0d want %0d", rd_count, NW); end
    for (int w = 0; w < NW; w++) begin
      vectors++;
      if (rd_words[w] !== exp_w[w]) begin miscompares++; $display("FAIL sat_word %0d got %0d want %0d", w, rd_words[w], exp_w[w]); end
    end
  endtask

  task automatic test_lane_err();
    clear_exp();
    vectors++; if (bus.lane_err !== 1'b0) begin miscompares++; $display("FAIL lane_err_pre got %b want 0", bus.lane_err); end
    vote(0, 0, 0, 1, 2, 0, 0);
    vectors++; if (bus.lane_err !== 1'b1) begin miscompares++; $display("FAIL lane_err_set got %b want 1", bus.lane_err); end
    vote(1, 3, 7, 0, 0, 0, 1);
    collect(1'b0, NW);
    vectors++; if (rd_count !== NW) begin miscompares++; $display("FAIL lane_err_count got %0d want %0d", rd_count, NW); end
    for (int w = 0; w < NW; w++) begin
      vectors++;
      if (rd_words[w] !== exp_w[w]) begin miscompares++; $display("FAIL lane_err_word %0d got %0d want %0d", w, rd_words[w], exp_w[w]); end
    end
    vote(0, 0, 0, 0, 0, 0, 1);
    collect(1'b0, NW);
    for (int w = 0; w < NW; w++) begin
      vectors++;
      if (rd_words[w] !== exp_w[w]) begin miscompares++; $display("FAIL lane_err_frame2_word %0d got %0d want %0d", w, rd_words[w], exp_w[w]); end
    end
    vectors++; if (bus.lane_err !== 1'b1) begin miscompares++; $display("FAIL lane_err_sticky got %b want 1", bus.lane_err); end
  endtask

  task automatic test_toggle_readout();
    clear_exp();
    exp_w[96] = 4'd2;
    exp_w[89] = 4'd1;
    vote(1, 6, 0, 1, 5, 9, 0);
    vote(1, 6, 0, 0, 0, 0, 1);
    collect(1'b1, NW);
    vectors++; if (rd_count !== NW) begin miscompares++; $display("FAIL toggle_count got %0d want %0d", rd_count, NW); end
    vectors++; if (rd_unstable !== 0) begin miscompares++; $display("FAIL toggle_stable got %0d changes want 0", rd_unstable); end
    for (int w = 0; w < NW; w++) begin
      vectors++;
      if (rd_words[w] !== exp_w[w]) begin miscompares++; $display("FAIL toggle_word %0d got %0d want %0d", w, rd_words[w], exp_w[w]); end
    end
    clear_exp();
    vote(0, 0, 0, 0, 0, 0, 1);
    collect(1'b0, NW);
    vectors++; if (rd_count !== NW) begin miscompares++; $display("FAIL reread_count got %0d want %0d", rd_count, NW); end
    for (int w = 0; w < NW; w++) begin
      vectors++;
      if (rd_words[w] !== exp_w[w]) begin miscompares++; $display("FAIL reread_word %0d got %0d want %0d", w, rd_words[w], exp_w[w]); end
    end
  endtask

  task automatic test_reset_mid_read();
    int cyc;
    clear_exp();
    vote(1, 4, 4, 0, 0, 0, 0);
    vote(0, 0, 0, 0, 0, 0, 1);
    collect(1'b0, 40);
    vectors++; if (rd_count !== 40) begin miscompares++; $display("FAIL midread_count got %0d want 40", rd_count); end
    reset = 1'b0;
    #1;
    vectors++; if (bus.out_empty !== 1'b1) begin miscompares++; $display("FAIL midread_empty got %b want 1", bus.out_empty); end
    vectors++; if (bus.vote_ready !== 1'b0) begin miscompares++; $display("FAIL midread_ready got %b want 0", bus.vote_ready); end
    step();
    reset = 1'b1;
    wait_ready(cyc);
    vectors++; if (cyc !== 64) begin miscompares++; $display("FAIL reinit_cycles got %0d want 64", cyc); end
    vote(0, 0, 0, 0, 0, 0, 1);
    collect(1'b0, NW);
    vectors++; if (rd_count !== NW) begin miscompares++; $display("FAIL rezero_count got %0d want %0d", rd_count, NW); end
    for (int w = 0; w < NW; w++) begin
      vectors++;
      if (rd_words[w] !== exp_w[w]) begin miscompares++; $display("FAIL rezero_word %0d got %0d want %0d", w, rd_words[w], exp_w[w]); end
    end
  endtask

  initial begin
    test_reset();
    test_empty_frame();
    test_votes();
    test_saturate();
    test_lane_err();
    test_toggle_readout();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired after %0d vectors", vectors);
    $fatal(1);
  end
endmodule
